// File: rtl/msg_seq_pkg.sv
// Shared state encoding and default sizes for the message transmit sequencer.
// No logic here, so there is no latency.
// No handshakes here, so there is no backpressure.
package msg_seq_pkg;

    localparam int DEF_DATA_W    = 8;
    localparam int DEF_MSG_DEPTH = 16;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD     = 3'd1,
        SEND     = 3'd2,
        HOLD     = 3'd3,
        WAIT_RDY = 3'd4,
        GAP      = 3'd5
    } seq_state_t;

endpackage

// File: rtl/msg_seq_ram.sv
// Message character store: one write port and one registered read port, contents not reset.
// Read latency is 1 cycle: rd_data reflects rd_addr as presented at the previous edge.
// No backpressure: every write is accepted; gating writes is the caller's job.
module msg_seq_ram
    import msg_seq_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_MSG_DEPTH,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              CLK,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/msg_tx_sequencer.sv
// Streams a RAM-held string into the UART controller, one character per send/ready handshake.
// Latency: start sampled at edge 1 gives a send pulse after edge 4; each character takes at least 4 cycles.
// Backpressure: waits in LOAD/WAIT_RDY on tx_ready_i; define MSG_SEQ_REPEAT_EN for repeat_i and the GAP loop.
module msg_tx_sequencer
    import msg_seq_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int MSG_DEPTH  = DEF_MSG_DEPTH,
`ifdef MSG_SEQ_REPEAT_EN
    parameter int GAP_CYCLES = 1000,
`endif
    localparam int IDX_W     = $clog2(MSG_DEPTH)
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              start_i,
    input  logic [IDX_W:0]    msg_len_i,
    input  logic              wr_en_i,
    input  logic [IDX_W-1:0]  wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              tx_ready_i,
`ifdef MSG_SEQ_REPEAT_EN
    input  logic              repeat_i,
`endif
    output logic              tx_send_o,
    output logic [DATA_W-1:0] tx_data_o,
    output logic              busy_o,
    output logic              done_o
);

    typedef logic [IDX_W:0] cnt_t;
    localparam cnt_t DEPTH_V = cnt_t'(MSG_DEPTH);

    logic              sync1, sync2, sync3;
    logic              start_rise;
    seq_state_t        state;
    cnt_t              idx;
    cnt_t              len;
    logic [IDX_W-1:0]  rd_addr;
    logic [DATA_W-1:0] rd_data;

`ifdef MSG_SEQ_REPEAT_EN
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);
    logic [GAP_W-1:0] gap_cnt;
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
        end else begin
            sync1 <= start_i;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign start_rise = sync2 & ~sync3;

    // Address the index the FSM will hold after the coming edge, so the
    // registered read data is already valid in the first LOAD cycle.
    always_comb begin
        rd_addr = '0;
        case (state)
            SEND:                 rd_addr = idx[IDX_W-1:0] + 1'b1;
            LOAD, HOLD, WAIT_RDY: rd_addr = idx[IDX_W-1:0];
            default:              rd_addr = '0;
        endcase
    end

    msg_seq_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (MSG_DEPTH)
    ) u_ram (
        .CLK     (CLK),
        .wr_en   (wr_en_i & ~busy_o),
        .wr_addr (wr_addr_i),
        .wr_data (wr_data_i),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= IDLE;
            idx       <= '0;
            len       <= '0;
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
            tx_send_o <= 1'b0;
            tx_data_o <= '0;
`ifdef MSG_SEQ_REPEAT_EN
            gap_cnt   <= '0;
`endif
        end else begin
            tx_send_o <= 1'b0;
            done_o    <= 1'b0;
            case (state)
                IDLE: begin
                    // An edge coinciding with the previous pass's done pulse is dropped.
                    if (start_rise && !done_o) begin
                        if (msg_len_i == '0) begin
                            done_o <= 1'b1;
                        end else begin
                            len    <= (msg_len_i > DEPTH_V) ? DEPTH_V : msg_len_i;
                            idx    <= '0;
                            busy_o <= 1'b1;
                            state  <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    if (tx_ready_i) begin
                        tx_data_o <= rd_data;
                        tx_send_o <= 1'b1;
                        state     <= SEND;
                    end
                end
                SEND: begin
                    idx   <= idx + 1'b1;
                    state <= HOLD;
                end
                HOLD: begin
                    state <= WAIT_RDY;
                end
                WAIT_RDY: begin
                    if (tx_ready_i) begin
                        if (idx < len) begin
                            state <= LOAD;
                        end else begin
                            done_o <= 1'b1;
`ifdef MSG_SEQ_REPEAT_EN
                            if (repeat_i) begin
                                gap_cnt <= '0;
                                state   <= GAP;
                            end else begin
                                busy_o <= 1'b0;
                                state  <= IDLE;
                            end
`else
                            busy_o <= 1'b0;
                            state  <= IDLE;
`endif
                        end
                    end
                end
`ifdef MSG_SEQ_REPEAT_EN
                GAP: begin
                    if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
                        idx   <= '0;
                        state <= LOAD;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
`endif
                default: begin
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule
